counter_sequencer: RTL and testbench
====================================

# counter_sequencer

Sequencing controller for a 4-bit parallel-carry up-counter. It runs the count under a 4-phase request/acknowledge handshake: it clears the count, enables counting, detects a programmable terminal count, then either signals completion (one-shot) or reloads and emits a periodic tick. The block sits between a requesting master (timer client) and the counter datapath, and it owns the count register so that clear, enable and terminal detection are coherent on one edge.

## Interface
- WIDTH, 4: counter width in bits; limit and count use this width.

- clock  in  1  system clock; all state updates on the falling edge
- reset_  in  1  asynchronous, active-low reset
- req  in  1  4-phase request from the master
- limit  in  WIDTH  terminal count, sampled only on acceptance
- periodic  in  1  mode, sampled only on acceptance: 0 = one-shot, 1 = periodic
- ack  out  1  one-shot completion acknowledge
- busy  out  1  high while counting (state COUNT); this is the counter enable (T)
- tick  out  1  one-cycle pulse per terminal count
- count  out  WIDTH  registered current count value

## Operation
- Internal registers: state, count, lim (latched limit), per (latched periodic). All outputs are registered.
- IDLE:
  - On an edge with req=1: count<=0, lim<=limit, per<=periodic, go to COUNT.
  - On an edge with req=0: no change; count holds its last value.
- COUNT, on each edge, first matching rule wins:
  - req=0 (abort or stop): go to IDLE; count holds; no tick; no ack.
  - count==lim and per=0: tick<=1, ack<=1, count holds lim, go to DONE.
  - count==lim and per=1: tick<=1, count<=0, stay in COUNT.
  - Otherwise: count<=count+1.
- DONE: ack stays 1. On an edge with req=0: ack<=0, go to IDLE. req=1 holds DONE indefinitely.
- tick is 0 on every edge not listed above, so it is never high for two consecutive cycles in one-shot mode.
- Period is lim+1 cycles. limit=0 gives a terminal at the first COUNT edge; in periodic mode tick is then high every cycle.
- Arithmetic: count never exceeds lim, so it never wraps. limit=2^WIDTH-1 gives a full-range period of 2^WIDTH cycles.
- Changes to limit or periodic outside the acceptance edge are ignored.
- Periodic mode never asserts ack; dropping req ends the run.

## Timing
- Reset (asynchronous, immediate, in any state): state=IDLE, count=0, lim=0, per=0, ack=0, busy=0, tick=0.
- Reset asserted mid-run discards the run with no ack and no tick. After release, a req still held high is accepted at the next falling edge.
- Acceptance at falling edge N gives busy=1 and count=0 after edge N. After edge N+k, count=k for k<=lim.
- Terminal is detected at edge N+1+lim, giving tick=1 during the following cycle:
  - One-shot: ack=1 and busy=0 after that edge; ack latency is lim+1 cycles from acceptance.
  - Periodic: count=0 after that edge, and ticks recur every lim+1 cycles.
- Simultaneous req drop and terminal in COUNT: the abort wins. Result is IDLE, no tick, no ack.
- The edge that drops ack returns the block to IDLE. A new request is accepted no earlier than the next edge.

## Test plan
- Reset, then one-shot with limit=5:
  - req high at edge 0 gives count 0,1,2,3,4,5 on edges 0–5.
  - tick and ack rise after edge 6; count holds 5 and busy=0.
  - req low at a later edge gives ack=0 after that edge, then IDLE.
- Periodic with limit=3, req held for 12 cycles:
  - tick after edges 4, 8 and 12, with count cycling 0..3.
  - ack stays 0 throughout.
  - req low gives IDLE on the next edge with busy=0.
- Boundary limits:
  - limit=0, one-shot: ack after the first COUNT edge.
  - limit=15, one-shot: ack 16 cycles after acceptance; count never reaches 0 again.
  - limit=0, periodic: tick high every cycle.
- Abort: limit=9, req dropped while count=4 → IDLE, count holds 4, no tick, no ack. Dropping req exactly at count==lim also produces no tick.
- Reset mid-run:
  - Assert reset_ low asynchronously while count=3: all outputs go to 0 immediately.
  - Release reset_ with req still high: request accepted at the next edge, count=0.
- Sampling check: changing limit from 5 to 2 during COUNT still gives ack after 6 cycles. Holding req high in DONE keeps ack=1 with no re-arm.

Source files
------------

// File: rtl/counter_sequencer.sv
// Sequencer for a 4-bit up-counter under a 4-phase req/ack handshake.
// Owns the count register so clear, enable and terminal detection share one falling edge.
module counter_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset_,
  input  logic             req,
  input  logic [WIDTH-1:0] limit,
  input  logic             periodic,
  output logic             ack,
  output logic             busy,
  output logic             tick,
  output logic [WIDTH-1:0] count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic [WIDTH-1:0] lim, lim_nxt;
  logic             per, per_nxt;
  logic             ack_nxt, tick_nxt;

  always_ff @(negedge clock or negedge reset_) begin
    if (!reset_) begin
      state <= IDLE;
      count <= '0;
      lim   <= '0;
      per   <= 1'b0;
      ack   <= 1'b0;
      busy  <= 1'b0;
      tick  <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      lim   <= lim_nxt;
      per   <= per_nxt;
      ack   <= ack_nxt;
      busy  <= (state_nxt == COUNT);
      tick  <= tick_nxt;
    end
  end

  // An abort (req low) takes priority over a terminal count on the same edge.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    lim_nxt   = lim;
    per_nxt   = per;
    ack_nxt   = 1'b0;
    tick_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          count_nxt = '0;
          lim_nxt   = limit;
          per_nxt   = periodic;
          state_nxt = COUNT;
        end
      end
      COUNT: begin
        if (!req) begin
          state_nxt = IDLE;
        end else if (count == lim) begin
          tick_nxt = 1'b1;
          if (per) begin
            count_nxt = '0;
          end else begin
            ack_nxt   = 1'b1;
            state_nxt = DONE;
          end
        end else begin
          count_nxt = count + 1'b1;
        end
      end
      DONE: begin
        if (req) begin
          ack_nxt = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: fixed vector table, directed corner sequences,
// and randomized traffic checked against a cycles-since-acceptance model.
module tb_counter_sequencer;
  localparam int WIDTH = 4;

  logic             clock = 1'b0;
  logic             reset_;
  logic             req;
  logic [WIDTH-1:0] limit;
  logic             periodic;
  logic             ack, busy, tick;
  logic [WIDTH-1:0] count;

  counter_sequencer #(.WIDTH(WIDTH)) dut (
    .clock(clock), .reset_(reset_), .req(req), .limit(limit), .periodic(periodic),
    .ack(ack), .busy(busy), .tick(tick), .count(count)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Model: mode 0 idle, 1 running, 2 done; k = falling edges since acceptance.
  int m_mode, m_k, m_l, m_cnt;
  bit m_p, m_tick, m_ack;

  typedef struct {
    bit       r;
    bit [3:0] l;
    bit       p;
    int       e_cnt;
    bit       e_tick, e_ack, e_busy;
  } vec_t;
  vec_t vt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_k = 0; m_l = 0; m_p = 0; m_cnt = 0; m_tick = 0; m_ack = 0;
  endtask

  task automatic model_edge(input bit r, input int l, input bit p);
    m_tick = 0;
    case (m_mode)
      0: if (r) begin
        m_mode = 1; m_k = 0; m_l = l; m_p = p; m_cnt = 0; m_ack = 0;
      end
      1: if (!r) begin
        m_mode = 0;
      end else begin
        m_k++;
        if (m_p) begin
          m_cnt  = m_k % (m_l + 1);
          m_tick = (m_cnt == 0);
        end else if (m_k == m_l + 1) begin
          m_mode = 2; m_cnt = m_l; m_tick = 1; m_ack = 1;
        end else begin
          m_cnt = m_k;
        end
      end
      default: if (!r) begin
        m_mode = 0; m_ack = 0;
      end
    endcase
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".count"}, count, m_cnt);
    chk({tag, ".tick"}, tick, m_tick);
    chk({tag, ".ack"}, ack, m_ack);
    chk({tag, ".busy"}, busy, (m_mode == 1));
  endtask

  task automatic step(input bit r, input int l, input bit p, input string tag);
    req = r; limit = l[3:0]; periodic = p;
    @(negedge clock);
    #1;
    model_edge(r, l, p);
    check_model(tag);
  endtask

  task automatic mid_reset(input string tag);
    #2 reset_ = 1'b0;
    #1;
    model_reset();
    chk({tag, ".rst_count"}, count, 0);
    chk({tag, ".rst_tick"}, tick, 0);
    chk({tag, ".rst_ack"}, ack, 0);
    chk({tag, ".rst_busy"}, busy, 0);
    #2 reset_ = 1'b1;
  endtask

  task automatic add(input bit r, input int l, input bit p, input int c,
                     input bit t, input bit a, input bit b);
    vec_t v;
    v.r = r; v.l = l[3:0]; v.p = p; v.e_cnt = c; v.e_tick = t; v.e_ack = a; v.e_busy = b;
    vt.push_back(v);
  endtask

  initial begin
    // One-shot limit=5, then periodic limit=3 held for 12 cycles.
    for (int i = 0; i <= 5; i++) add(1, 5, 0, i, 0, 0, 1);
    add(1, 5, 0, 5, 1, 1, 0);
    add(1, 5, 0, 5, 0, 1, 0);
    add(0, 5, 0, 5, 0, 0, 0);
    add(0, 5, 0, 5, 0, 0, 0);
    add(1, 3, 1, 0, 0, 0, 1);
    for (int c = 1; c <= 3; c++) begin
      for (int i = 1; i <= 3; i++) add(1, 3, 1, i, 0, 0, 1);
      add(1, 3, 1, 0, 1, 0, 1);
    end
    add(0, 3, 1, 0, 0, 0, 0);

    reset_ = 1'b0; req = 1'b0; limit = '0; periodic = 1'b0;
    model_reset();
    #12;
    chk("reset.count", count, 0);
    chk("reset.tick", tick, 0);
    chk("reset.ack", ack, 0);
    chk("reset.busy", busy, 0);
    reset_ = 1'b1;

    foreach (vt[i]) begin
      req = vt[i].r; limit = vt[i].l; periodic = vt[i].p;
      @(negedge clock);
      #1;
      model_edge(vt[i].r, vt[i].l, vt[i].p);
      chk($sformatf("vec%0d.count", i), count, vt[i].e_cnt);
      chk($sformatf("vec%0d.tick", i), tick, vt[i].e_tick);
      chk($sformatf("vec%0d.ack", i), ack, vt[i].e_ack);
      chk($sformatf("vec%0d.busy", i), busy, vt[i].e_busy);
    end

    // limit=0 one-shot: ack after the first COUNT edge.
    step(1, 0, 0, "l0os_acc");
    step(1, 0, 0, "l0os_term");
    chk("l0os.ack_direct", ack, 1);
    step(0, 0, 0, "l0os_rel");

    // limit=15 one-shot: full range, ack 16 cycles after acceptance.
    step(1, 15, 0, "l15_acc");
    for (int i = 1; i <= 15; i++) step(1, 15, 0, "l15_run");
    chk("l15.count15", count, 15);
    step(1, 15, 0, "l15_term");
    chk("l15.ack_direct", ack, 1);
    step(0, 15, 0, "l15_rel");

    // limit=0 periodic: tick every cycle.
    step(1, 0, 1, "l0p_acc");
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 1, "l0p_run");
      chk("l0p.tick_direct", tick, 1);
    end
    step(0, 0, 1, "l0p_rel");

    // Abort at count=4 with limit=9.
    step(1, 9, 0, "ab4_acc");
    for (int i = 1; i <= 4; i++) step(1, 9, 0, "ab4_run");
    step(0, 9, 0, "ab4_drop");
    chk("ab4.count_held", count, 4);
    step(0, 9, 0, "ab4_idle");

    // Abort exactly when count==lim: no tick.
    step(1, 2, 1, "abt_acc");
    step(1, 2, 1, "abt_run");
    step(1, 2, 1, "abt_run");
    step(0, 2, 1, "abt_drop");
    chk("abt.no_tick", tick, 0);

    // limit changed 5 -> 2 during COUNT is ignored; DONE held with req high.
    step(1, 5, 0, "smp_acc");
    for (int i = 1; i <= 5; i++) step(1, 2, 1, "smp_run");
    step(1, 2, 1, "smp_term");
    chk("smp.ack_after6", ack, 1);
    for (int i = 0; i < 4; i++) step(1, 2, 1, "smp_hold");
    step(0, 2, 1, "smp_rel");

    // Asynchronous reset at count=3, req still high on release.
    step(1, 9, 0, "rst_acc");
    for (int i = 1; i <= 3; i++) step(1, 9, 0, "rst_run");
    mid_reset("midrun");
    step(1, 9, 0, "rst_reacc");
    chk("rst.reacc_count", count, 0);
    step(0, 9, 0, "rst_rel");

    // Randomized traffic.
    begin
      bit r = 0;
      for (int i = 0; i < 600; i++) begin
        if (r) r = ($urandom_range(0, 11) != 0);
        else   r = ($urandom_range(0, 2) == 0);
        step(r, $urandom_range(0, 15), $urandom_range(0, 1), "rnd");
        if ($urandom_range(0, 59) == 0) mid_reset("rnd");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
